// File: rtl/fp_exe_sched_pkg.sv
// Shared types for the FPU execute-stage issue scheduler (fp_exe_sched).
package fp_exe_sched_pkg;

  localparam int FP_SCHED_TAG_W = 5;

  typedef enum logic [1:0] {
    SCHED_MISC = 2'd0,
    SCHED_CVT  = 2'd1,
    SCHED_FMA  = 2'd2,
    SCHED_DIV  = 2'd3
  } fp_sched_unit_t;

  // Class bits of a decoded FP op; ops with none of these set (moves, sign-inject,
  // compares, classify) are single-cycle MISC work.
  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmadd;
    logic fnmsub;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fcvt_f2f;
    logic fcvt_i2f;
  } fp_operation_type;

  typedef struct packed {
    logic                      valid;
    fp_sched_unit_t            unit;
    logic [FP_SCHED_TAG_W-1:0] tag;
  } fp_sched_slot_type;

  localparam fp_sched_slot_type init_fp_sched_slot = '{valid: 1'b0, unit: SCHED_MISC, tag: 5'd0};

  function automatic logic is_fma_op(input fp_operation_type op);
    return op.fmadd | op.fmsub | op.fnmadd | op.fnmsub | op.fadd | op.fsub | op.fmul;
  endfunction

endpackage

// File: rtl/fp_exe_sched_resv.sv
// Write-back reservation table: slot i holds the op that writes back i cycles from now.
module fp_sched_resv
  import fp_exe_sched_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int TAG_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ins_valid,
  input  logic [$clog2(DEPTH+1)-1:0] ins_lat,
  input  logic [1:0]                 ins_unit,
  input  logic [TAG_W-1:0]           ins_tag,
  output logic [DEPTH:0]             busy,
  output logic                       out_valid,
  output logic [1:0]                 out_unit,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int LAT_W = $clog2(DEPTH + 1);

  logic [DEPTH:0]            valid_q, valid_d;
  logic [DEPTH:0][1:0]       unit_q, unit_d;
  logic [DEPTH:0][TAG_W-1:0] tag_q, tag_d;

  // Shift toward slot 0; an op of latency L lands in slot L-1 after this edge.
  always_comb begin
    valid_d = '0;
    unit_d  = '0;
    tag_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_valid && (ins_lat == LAT_W'(i + 1))) begin
        valid_d[i] = 1'b1;
        unit_d[i]  = ins_unit;
        tag_d[i]   = ins_tag;
      end else begin
        valid_d[i] = valid_q[i+1];
        unit_d[i]  = unit_q[i+1];
        tag_d[i]   = tag_q[i+1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      unit_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      unit_q  <= unit_d;
      tag_q   <= tag_d;
    end
  end

  assign busy      = valid_q;
  assign out_valid = valid_q[0];
  assign out_unit  = unit_q[0];
  assign out_tag   = tag_q[0];

endmodule

// File: rtl/fp_exe_sched.sv
// FPU execute-stage issue scheduler: decode to unit, reserve write-back slots, merge divider results.
// Optional FP_SCHED_PERF_EN adds saturating stall_cnt / div_wait_cnt performance outputs.
module fp_exe_sched
  import fp_exe_sched_pkg::*;
#(
  parameter int FMA_LAT = 3,
  parameter int CVT_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp_operation_type req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             iss_valid,
  output logic [1:0]       iss_unit,
  input  logic             div_done,
  output logic             div_ack,
  output logic             wb_valid,
  output logic [1:0]       wb_unit,
  output logic [TAG_W-1:0] wb_tag
`ifdef FP_SCHED_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      div_wait_cnt
`endif
);

  localparam int LAT_W = $clog2(FMA_LAT + 1);

  fp_sched_unit_t   dec_unit;
  logic [LAT_W-1:0] dec_lat;
  logic             div_busy_q, div_busy_d;
  logic [TAG_W-1:0] div_tag_q, div_tag_d;
  logic             div_pend, accept, fixed_ins;
  logic [FMA_LAT:0] res_busy;
  logic             slot_valid;
  logic [1:0]       slot_unit;
  logic [TAG_W-1:0] slot_tag;

  always_comb begin
    if (req_op.fdiv | req_op.fsqrt) begin
      dec_unit = SCHED_DIV;
      dec_lat  = '0;
    end else if (is_fma_op(req_op)) begin
      dec_unit = SCHED_FMA;
      dec_lat  = LAT_W'(FMA_LAT);
    end else if (req_op.fcvt_f2f | req_op.fcvt_i2f) begin
      dec_unit = SCHED_CVT;
      dec_lat  = LAT_W'(CVT_LAT);
    end else begin
      dec_unit = SCHED_MISC;
      dec_lat  = LAT_W'(1);
    end
  end

  // A pending divider result freezes issue so the table drains and DIV gets a slot.
  always_comb begin
    div_pend = div_done & div_busy_q;
    if (dec_unit == SCHED_DIV) begin
      req_ready = !reset & !div_pend & !div_busy_q;
    end else begin
      req_ready = !reset & !div_pend & !res_busy[dec_lat];
    end
    accept    = req_valid & req_ready;
    fixed_ins = accept & (dec_unit != SCHED_DIV);
    iss_valid = accept;
    iss_unit  = accept ? dec_unit : SCHED_MISC;
  end

  always_comb begin
    div_ack = div_pend & !slot_valid;
    if (slot_valid) begin
      wb_valid = 1'b1;
      wb_unit  = slot_unit;
      wb_tag   = slot_tag;
    end else if (div_pend) begin
      wb_valid = 1'b1;
      wb_unit  = SCHED_DIV;
      wb_tag   = div_tag_q;
    end else begin
      wb_valid = 1'b0;
      wb_unit  = SCHED_MISC;
      wb_tag   = '0;
    end
    if (div_ack) begin
      div_busy_d = 1'b0;
    end else if (accept && (dec_unit == SCHED_DIV)) begin
      div_busy_d = 1'b1;
    end else begin
      div_busy_d = div_busy_q;
    end
    div_tag_d = (accept && (dec_unit == SCHED_DIV)) ? req_tag : div_tag_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_busy_q <= 1'b0;
      div_tag_q  <= '0;
    end else begin
      div_busy_q <= div_busy_d;
      div_tag_q  <= div_tag_d;
    end
  end

  fp_sched_resv #(
    .DEPTH (FMA_LAT),
    .TAG_W (TAG_W)
  ) u_resv (
    .clock     (clock),
    .reset     (reset),
    .ins_valid (fixed_ins),
    .ins_lat   (dec_lat),
    .ins_unit  (dec_unit),
    .ins_tag   (req_tag),
    .busy      (res_busy),
    .out_valid (slot_valid),
    .out_unit  (slot_unit),
    .out_tag   (slot_tag)
  );

`ifdef FP_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, div_wait_cnt_q, div_wait_cnt_d;

  always_comb begin
    if (req_valid && !req_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (div_pend && !div_ack && (div_wait_cnt_q != 32'hFFFF_FFFF)) begin
      div_wait_cnt_d = div_wait_cnt_q + 32'd1;
    end else begin
      div_wait_cnt_d = div_wait_cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q    <= 32'd0;
      div_wait_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      div_wait_cnt_q <= div_wait_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign div_wait_cnt = div_wait_cnt_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
